// File: rtl/pll_mode_pkg.sv
// -----------------------------------------------------------------------------
// pll_mode_pkg
// Shared definitions for the video PLL mode sequencer:
//   - sequencer state encoding
//   - divider code bundle (three raw 6-bit codes, exactly as the PLL takes them)
//   - the per-mode divider table and the power-on default mode
// -----------------------------------------------------------------------------
package pll_mode_pkg;

  localparam int unsigned MODE_W      = 2;  // width of mode_sel / mode_cur
  localparam int unsigned TABLE_MODES = 4;  // entries present in mode_codes()
  localparam int unsigned DIV_W       = 6;  // width of each PLL divider code

  localparam logic [MODE_W-1:0] DEFAULT_MODE_IDX = '0;

  typedef enum logic [2:0] {
    ST_READY,
    ST_QUIESCE,
    ST_APPLY,
    ST_HOLD,
    ST_WAIT_LOCK,
    ST_FAULT
  } seq_state_e;

  typedef struct packed {
    logic [DIV_W-1:0] fbdsel;
    logic [DIV_W-1:0] idsel;
    logic [DIV_W-1:0] odsel;
  } div_codes_t;

  // Divider table. Codes are the raw register values the PLL consumes,
  // not divide ratios, so no encoding happens anywhere downstream.
  function automatic div_codes_t mode_codes(input logic [MODE_W-1:0] mode);
    div_codes_t codes;
    codes = '0;
    case (mode)
      2'd0: codes = '{fbdsel: 6'h12, idsel: 6'h01, odsel: 6'h08};
      2'd1: codes = '{fbdsel: 6'h1D, idsel: 6'h02, odsel: 6'h04};
      2'd2: codes = '{fbdsel: 6'h2A, idsel: 6'h03, odsel: 6'h02};
      2'd3: codes = '{fbdsel: 6'h35, idsel: 6'h05, odsel: 6'h01};
      default: codes = '0;
    endcase
    return codes;
  endfunction

endpackage

// File: rtl/pll_mode_sequencer_if.sv
// -----------------------------------------------------------------------------
// pll_mode_sequencer_if
// Mode-request port of the PLL mode sequencer.
//   mode_req  master->slave  single-cycle request to switch to mode_sel
//   mode_sel  master->slave  requested mode index
//   mode_cur  slave->master  mode currently applied to the PLL
//   busy      slave->master  sequence in progress; requests are dropped
//   fault     slave->master  lock was not achieved in time
// -----------------------------------------------------------------------------
interface pll_mode_sequencer_if;
  import pll_mode_pkg::*;

  logic              mode_req;
  logic [MODE_W-1:0] mode_sel;
  logic [MODE_W-1:0] mode_cur;
  logic              busy;
  logic              fault;

  modport master (
    output mode_req,
    output mode_sel,
    input  mode_cur,
    input  busy,
    input  fault
  );

  modport slave (
    input  mode_req,
    input  mode_sel,
    output mode_cur,
    output busy,
    output fault
  );

endinterface

// File: rtl/sync_bit.sv
// -----------------------------------------------------------------------------
// sync_bit
// Multi-flop synchroniser for a single asynchronous level.
//   clk  in  destination clock
//   rst  in  asynchronous active-high reset, chain clears to 0
//   d    in  asynchronous input
//   q    out synchronised copy of d, STAGES cycles of latency
// -----------------------------------------------------------------------------
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // NOTE: every signal an always_comb block writes gets a value on every
  // path; otherwise synthesis infers a latch.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // NOTE: state registers use non-blocking assignment so all flops sample
  // their inputs from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_mode_sequencer.sv
// -----------------------------------------------------------------------------
// pll_mode_sequencer
// Drives the reconfigurable video PLL divider codes from a per-mode table and
// supervises PLL lock, holding the pixel-clock pipeline in reset whenever the
// pixel clock is changing or unlocked. Runs on the reference clock only.
//
// Ports
//   clk        in   reference clock
//   rst        in   asynchronous active-high reset
//   req_if     slave  mode_req/mode_sel in; mode_cur/busy/fault out
//   pll_lock   in   raw PLL lock, asynchronous to clk
//   fbdsel     out  PLL feedback divider code
//   idsel      out  PLL input divider code
//   odsel      out  PLL output divider code
//   video_rst  out  reset to the pixel-clock domain, low only in READY
//
// Sequence: READY -> QUIESCE (video held in reset) -> APPLY (dividers change)
// -> HOLD (lock ignored while the PLL relocks) -> WAIT_LOCK (lock must stay
// high SETTLE_CYCLES in a row) -> READY, or FAULT on timeout.
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module pll_mode_sequencer
  import pll_mode_pkg::*;
#(
  parameter int unsigned       N_MODES        = 4,        // must not exceed TABLE_MODES
  parameter logic [MODE_W-1:0] DEFAULT_MODE   = DEFAULT_MODE_IDX,
  parameter int unsigned       SYNC_STAGES    = 2,
  parameter int unsigned       QUIESCE_CYCLES = 16,
  parameter int unsigned       HOLD_CYCLES    = 64,
  parameter int unsigned       SETTLE_CYCLES  = 1024,
  parameter int unsigned       LOCK_TIMEOUT   = 1048576
) (
  input  logic                 clk,
  input  logic                 rst,
  pll_mode_sequencer_if.slave  req_if,
  input  logic                 pll_lock,
  output logic [DIV_W-1:0]     fbdsel,
  output logic [DIV_W-1:0]     idsel,
  output logic [DIV_W-1:0]     odsel,
  output logic                 video_rst
);

  // QUIESCE and HOLD never overlap, so they share one phase counter.
  localparam int unsigned PHASE_MAX = (QUIESCE_CYCLES > HOLD_CYCLES) ? QUIESCE_CYCLES
                                                                     : HOLD_CYCLES;
  localparam int unsigned PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam int unsigned SETTLE_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TIMEOUT_W = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [PHASE_W-1:0]   PHASE_SAT    = PHASE_W'(PHASE_MAX);
  localparam logic [PHASE_W-1:0]   QUIESCE_LAST = PHASE_W'(QUIESCE_CYCLES - 1);
  localparam logic [PHASE_W-1:0]   HOLD_LAST    = PHASE_W'(HOLD_CYCLES - 1);
  localparam logic [SETTLE_W-1:0]  SETTLE_SAT   = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [SETTLE_W-1:0]  SETTLE_LAST  = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_SAT  = TIMEOUT_W'(LOCK_TIMEOUT);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(LOCK_TIMEOUT - 1);

  seq_state_e           state_q,     state_d;
  logic [PHASE_W-1:0]   phase_q,     phase_d;
  logic [SETTLE_W-1:0]  settle_q,    settle_d;
  logic [TIMEOUT_W-1:0] timeout_q,   timeout_d;
  logic [MODE_W-1:0]    target_q,    target_d;
  logic [MODE_W-1:0]    mode_cur_q,  mode_cur_d;
  div_codes_t           div_q,       div_d;
  logic                 busy_q,      busy_d;
  logic                 video_rst_q, video_rst_d;
  logic                 fault_q,     fault_d;

  logic lock_s;
  logic mode_in_range;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // With a full table every encodable index is valid, so no compare is built.
  if (N_MODES >= (1 << MODE_W)) begin : g_full_table
    assign mode_in_range = 1'b1;
  end else begin : g_partial_table
    assign mode_in_range = (req_if.mode_sel < MODE_W'(N_MODES));
  end

  // ---------------------------------------------------------------------------
  // Next-state, counters and registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    mode_cur_d = mode_cur_q;
    div_d      = div_q;

    unique case (state_q)
      ST_READY: begin
        // A valid request wins over a simultaneous lock loss: the switch
        // sequence re-qualifies lock in WAIT_LOCK anyway.
        if (req_if.mode_req && mode_in_range && (req_if.mode_sel != mode_cur_q)) begin
          target_d = req_if.mode_sel;
          state_d  = ST_QUIESCE;
        end else if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_QUIESCE: begin
        if (phase_q == QUIESCE_LAST) begin
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        div_d      = mode_codes(target_q);
        mode_cur_d = target_q;
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        // lock_s is deliberately not looked at: the PLL drops lock while
        // it re-acquires after a divider change.
        if (phase_q == HOLD_LAST) begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        // Settle is tested first so it wins a tie with the timeout.
        if (lock_s && (settle_q == SETTLE_LAST)) begin
          state_d = ST_READY;
        end else if (timeout_q == TIMEOUT_LAST) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        // Re-requesting the current mode is the recovery path, so no
        // mode_sel != mode_cur filter here.
        if (req_if.mode_req && mode_in_range) begin
          target_d = req_if.mode_sel;
          state_d  = ST_QUIESCE;
        end
      end
      default: begin
        state_d = ST_HOLD;
      end
    endcase

    // Counters restart from zero on every state entry, and only run in the
    // states that use them.
    phase_d   = '0;
    settle_d  = '0;
    timeout_d = '0;
    if (state_d == state_q) begin
      if ((state_q == ST_QUIESCE) || (state_q == ST_HOLD)) begin
        phase_d = (phase_q == PHASE_SAT) ? phase_q : phase_q + PHASE_W'(1);
      end
      if (state_q == ST_WAIT_LOCK) begin
        if (lock_s) begin
          settle_d = (settle_q == SETTLE_SAT) ? settle_q : settle_q + SETTLE_W'(1);
        end
        timeout_d = (timeout_q == TIMEOUT_SAT) ? timeout_q : timeout_q + TIMEOUT_W'(1);
      end
    end

    // Outputs are decoded from the next state so they switch on the same
    // edge as the state register.
    busy_d      = (state_d != ST_READY) && (state_d != ST_FAULT);
    video_rst_d = (state_d != ST_READY);
    fault_d     = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HOLD;
      phase_q     <= '0;
      settle_q    <= '0;
      timeout_q   <= '0;
      target_q    <= DEFAULT_MODE;
      mode_cur_q  <= DEFAULT_MODE;
      div_q       <= mode_codes(DEFAULT_MODE);
      busy_q      <= 1'b1;
      video_rst_q <= 1'b1;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      settle_q    <= settle_d;
      timeout_q   <= timeout_d;
      target_q    <= target_d;
      mode_cur_q  <= mode_cur_d;
      div_q       <= div_d;
      busy_q      <= busy_d;
      video_rst_q <= video_rst_d;
      fault_q     <= fault_d;
    end
  end

  assign fbdsel          = div_q.fbdsel;
  assign idsel           = div_q.idsel;
  assign odsel           = div_q.odsel;
  assign video_rst       = video_rst_q;
  assign req_if.mode_cur = mode_cur_q;
  assign req_if.busy     = busy_q;
  assign req_if.fault    = fault_q;

endmodule

// File: tb/tb_pll_mode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_mode_sequencer
// Directed bench for pll_mode_sequencer. The DUT is built with N_MODES=3 so
// mode 3 is an out-of-range request, and with a short LOCK_TIMEOUT so the
// fault path is reachable in a short run. Expected divider codes are typed in
// here independently of the RTL package.
// -----------------------------------------------------------------------------
module tb_pll_mode_sequencer;

  localparam int SETTLE  = 1024;
  localparam int TIMEOUT = 3000;
  localparam int LIMIT   = 2000;

  // {fbdsel, idsel, odsel}
  localparam logic [17:0] DIV_M0 = {6'h12, 6'h01, 6'h08};
  localparam logic [17:0] DIV_M1 = {6'h1D, 6'h02, 6'h04};
  localparam logic [17:0] DIV_M2 = {6'h2A, 6'h03, 6'h02};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b0;
  logic [5:0] fbdsel;
  logic [5:0] idsel;
  logic [5:0] odsel;
  logic       video_rst;
  logic [17:0] div_all;

  int errors = 0;
  int checks = 0;

  pll_mode_sequencer_if req_if ();

  pll_mode_sequencer #(
    .N_MODES        (3),
    .DEFAULT_MODE   (2'd0),
    .SYNC_STAGES    (2),
    .QUIESCE_CYCLES (16),
    .HOLD_CYCLES    (64),
    .SETTLE_CYCLES  (SETTLE),
    .LOCK_TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_if    (req_if),
    .pll_lock  (pll_lock),
    .fbdsel    (fbdsel),
    .idsel     (idsel),
    .odsel     (odsel),
    .video_rst (video_rst)
  );

  always #5 clk = ~clk;

  assign div_all = {fbdsel, idsel, odsel};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Single-cycle request; returns just after the edge that samples it.
  task automatic request(input logic [1:0] m);
    req_if.mode_req = 1'b1;
    req_if.mode_sel = m;
    step(1);
    req_if.mode_req = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while ((req_if.busy !== 1'b0) && (n < LIMIT)) begin
      step(1);
      n++;
    end
    check(tag, req_if.busy, 1'b0);
  endtask

  initial begin
    req_if.mode_req = 1'b0;
    req_if.mode_sel = 2'd0;

    // 1. Reset state, then lock arrives 200 cycles after reset release.
    #23;
    check("rst_busy",  req_if.busy,     1'b1);
    check("rst_vrst",  video_rst,       1'b1);
    check("rst_fault", req_if.fault,    1'b0);
    check("rst_mode",  req_if.mode_cur, 2'd0);
    check("rst_div",   div_all,         DIV_M0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(200);
    check("t1_div_prelock",  div_all,     DIV_M0);
    check("t1_vrst_prelock", video_rst,   1'b1);
    check("t1_busy_prelock", req_if.busy, 1'b1);
    pll_lock = 1'b1;
    step(SETTLE + 1);
    check("t1_vrst_edge_m1", video_rst,   1'b1);
    check("t1_busy_edge_m1", req_if.busy, 1'b1);
    step(1);
    check("t1_vrst_ready", video_rst,       1'b0);
    check("t1_busy_ready", req_if.busy,     1'b0);
    check("t1_div_ready",  div_all,         DIV_M0);
    check("t1_mode_ready", req_if.mode_cur, 2'd0);

    // 2. Switch to mode 2; busy request and HOLD lock glitch must be ignored.
    request(2'd2);
    check("t2_vrst_accept", video_rst,   1'b1);
    check("t2_busy_accept", req_if.busy, 1'b1);
    check("t2_div_accept",  div_all,     DIV_M0);
    step(5);
    req_if.mode_req = 1'b1;
    req_if.mode_sel = 2'd1;
    step(1);
    req_if.mode_req = 1'b0;
    step(10);
    check("t2_div_at16",  div_all,         DIV_M0);
    check("t2_mode_at16", req_if.mode_cur, 2'd0);
    step(1);
    check("t2_div_at17",  div_all,         DIV_M2);
    check("t2_mode_at17", req_if.mode_cur, 2'd2);
    step(13);
    pll_lock = 1'b0;
    step(3);
    pll_lock = 1'b1;
    step(80 + SETTLE - 33);
    check("t2_vrst_edge_m1", video_rst, 1'b1);
    step(1);
    check("t2_vrst_ready", video_rst,       1'b0);
    check("t2_busy_ready", req_if.busy,     1'b0);
    check("t2_mode_final", req_if.mode_cur, 2'd2);
    check("t2_div_final",  div_all,         DIV_M2);

    // 3. Same-mode and out-of-range requests in READY are ignored.
    request(2'd2);
    check("t3_same_busy", req_if.busy, 1'b0);
    check("t3_same_vrst", video_rst,   1'b0);
    step(20);
    check("t3_same_vrst_late", video_rst, 1'b0);
    check("t3_same_div",       div_all,   DIV_M2);
    request(2'd3);
    check("t3_oor_busy", req_if.busy, 1'b0);
    check("t3_oor_vrst", video_rst,   1'b0);
    step(20);
    check("t3_oor_vrst_late", video_rst,       1'b0);
    check("t3_oor_mode",      req_if.mode_cur, 2'd2);
    check("t3_oor_div",       div_all,         DIV_M2);

    // 4. Lock drops low for 4 cycles every 500: settle never completes.
    for (int k = 0; k < TIMEOUT + 2; k++) begin
      pll_lock = ((k % 500) >= 4);
      step(1);
    end
    check("t4_fault_pre", req_if.fault, 1'b0);
    check("t4_busy_pre",  req_if.busy,  1'b1);
    check("t4_vrst_pre",  video_rst,    1'b1);
    pll_lock = 1'b0;
    step(1);
    check("t4_fault", req_if.fault, 1'b1);
    check("t4_busy",  req_if.busy,  1'b0);
    check("t4_vrst",  video_rst,    1'b1);
    check("t4_div",   div_all,      DIV_M2);
    request(2'd3);
    check("t4_oor_fault", req_if.fault, 1'b1);
    check("t4_oor_busy",  req_if.busy,  1'b0);
    request(2'd2);
    check("t4_clr_fault", req_if.fault, 1'b0);
    check("t4_clr_busy",  req_if.busy,  1'b1);
    check("t4_clr_vrst",  video_rst,    1'b1);
    pll_lock = 1'b1;
    wait_ready("t4_recover");
    check("t4_rec_vrst", video_rst,       1'b0);
    check("t4_rec_mode", req_if.mode_cur, 2'd2);
    check("t4_rec_div",  div_all,         DIV_M2);

    // 5. Three-cycle lock drop in READY.
    pll_lock = 1'b0;
    step(2);
    check("t5_vrst_pre", video_rst, 1'b0);
    step(1);
    check("t5_vrst_up", video_rst,   1'b1);
    check("t5_busy_up", req_if.busy, 1'b1);
    check("t5_div_up",  div_all,     DIV_M2);
    pll_lock = 1'b1;
    step(SETTLE + 1);
    check("t5_vrst_edge_m1", video_rst, 1'b1);
    step(1);
    check("t5_vrst_ready", video_rst,       1'b0);
    check("t5_busy_ready", req_if.busy,     1'b0);
    check("t5_div_ready",  div_all,         DIV_M2);
    check("t5_mode_ready", req_if.mode_cur, 2'd2);

    // 6. Reset during QUIESCE, then during HOLD.
    request(2'd1);
    step(5);
    rst = 1'b1;
    #1;
    check("t6q_div",   div_all,         DIV_M0);
    check("t6q_mode",  req_if.mode_cur, 2'd0);
    check("t6q_vrst",  video_rst,       1'b1);
    check("t6q_busy",  req_if.busy,     1'b1);
    check("t6q_fault", req_if.fault,    1'b0);
    #3;
    rst = 1'b0;
    wait_ready("t6q_ready");
    check("t6q_mode_after", req_if.mode_cur, 2'd0);
    request(2'd1);
    step(17);
    check("t6h_div_applied",  div_all,         DIV_M1);
    check("t6h_mode_applied", req_if.mode_cur, 2'd1);
    step(10);
    rst = 1'b1;
    #1;
    check("t6h_div",  div_all,         DIV_M0);
    check("t6h_mode", req_if.mode_cur, 2'd0);
    check("t6h_vrst", video_rst,       1'b1);
    check("t6h_busy", req_if.busy,     1'b1);
    #3;
    rst = 1'b0;
    wait_ready("t6h_ready");
    check("t6h_div_after", div_all, DIV_M0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
